dec_nx2n_scan: RTL

DEC_NX2N_SCAN -- requirements
Module: dec_nx2n_scan

---
 rtl/dec_pkg.sv | 28 ++
 rtl/dec_scan_cnt.sv | 61 ++++++
 rtl/dec_nx2n_scan.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/dec_pkg.sv
// dec_pkg: shared FSM state type and one-hot decode helper for dec_nx2n_scan.
// Optional feature macro: DEC_SCAN_EN (adds the SCAN state when defined).
package dec_pkg;

    // Widest select code the decode helper handles; callers keep the low 2**N bits.
    localparam int DEC_MAX_N = 8;
    localparam int DEC_MAX_W = 2 ** DEC_MAX_N;

`ifdef DEC_SCAN_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } dec_state_e;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1
    } dec_state_e;
`endif

    // One-hot of a zero-extended select code; bit k is set for code k, so the
    // low 2**N bits are the N-bit decode for any N up to DEC_MAX_N.
    function automatic logic [DEC_MAX_W-1:0] dec_onehot(input logic [DEC_MAX_N-1:0] code);
        dec_onehot = {{(DEC_MAX_W-1){1'b0}}, 1'b1} << code;
    endfunction

endpackage

// File: rtl/dec_scan_cnt.sv
// dec_scan_cnt: dwell counter and scan index for dec_nx2n_scan.
// Only instantiated when DEC_SCAN_EN is defined.
module dec_scan_cnt
    import dec_pkg::*;
#(
    parameter int N       = 3,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_run,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic [N-1:0]       o_index_nxt,
    output logic               o_change
);

    logic [N-1:0]       r_index;
    logic [N-1:0]       w_index_nxt;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] w_cnt_nxt;

    // Start restarts at index 0; while running, step the index once the count
    // reaches dwell. ">=" lets a dwell lowered below the running count take
    // effect on the very next comparison instead of waiting for a wrap.
    always_comb begin
        w_index_nxt = r_index;
        w_cnt_nxt   = r_cnt;
        o_change    = 1'b0;
        if (i_start) begin
            w_index_nxt = {N{1'b0}};
            w_cnt_nxt   = {DWELL_W{1'b0}};
            o_change    = 1'b1;
        end else if (i_run) begin
            if (r_cnt >= i_dwell) begin
                w_index_nxt = r_index + N'(1'b1);
                w_cnt_nxt   = {DWELL_W{1'b0}};
                o_change    = 1'b1;
            end else begin
                w_cnt_nxt   = r_cnt + DWELL_W'(1'b1);
            end
        end else begin
            w_index_nxt = r_index;
            w_cnt_nxt   = r_cnt;
        end
    end

    assign o_index_nxt = w_index_nxt;

    // Index and dwell count registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_index <= {N{1'b0}};
            r_cnt   <= {DWELL_W{1'b0}};
        end else begin
            r_index <= w_index_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/dec_nx2n_scan.sv
// dec_nx2n_scan: registered N-to-2**N one-hot decoder with an optional scan mode.
// Optional feature macro: DEC_SCAN_EN. When defined, mode=1 walks y through every
// index holding each for dwell+1 cycles; when undefined, mode and dwell are ignored.
module dec_nx2n_scan
    import dec_pkg::*;
#(
    parameter int N       = 3,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [N-1:0]       d,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2**N-1:0]    y,
    output logic               out_valid
);

    dec_state_e           r_state;
    dec_state_e           w_state_nxt;
    logic [N-1:0]         r_code;
    logic [N-1:0]         w_code_nxt;
    logic [2**N-1:0]      r_y;
    logic [2**N-1:0]      w_y_nxt;
    logic                 r_out_valid;
    logic                 w_out_valid_nxt;
    logic                 w_accept;
    logic [DEC_MAX_W-1:0] w_oh_wide;
    logic                 w_scan_chg;
    logic [N-1:0]         w_scan_idx_nxt;
    logic                 w_unused;

`ifdef DEC_SCAN_EN
    logic w_scan_start;
    logic w_scan_run;

    // Next state: IDLE lasts one cycle, then mode picks DIRECT or SCAN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (mode) w_state_nxt = SCAN;
                else      w_state_nxt = DIRECT;
            end
            DIRECT: begin
                if (mode) w_state_nxt = SCAN;
                else      w_state_nxt = DIRECT;
            end
            SCAN: begin
                if (mode) w_state_nxt = SCAN;
                else      w_state_nxt = DIRECT;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Codes are only taken in DIRECT and only while mode still asks for it.
    assign in_ready     = (r_state == DIRECT) && !mode;
    // Any entry into SCAN restarts the walk at index 0.
    assign w_scan_start = (w_state_nxt == SCAN) && (r_state != SCAN);
    assign w_scan_run   = (r_state == SCAN) && mode;

    dec_scan_cnt #(
        .N       (N),
        .DWELL_W (DWELL_W)
    ) u_scan_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_scan_start),
        .i_run       (w_scan_run),
        .i_dwell     (dwell),
        .o_index_nxt (w_scan_idx_nxt),
        .o_change    (w_scan_chg)
    );

    assign w_unused = ^{w_oh_wide};
`else
    // Next state: IDLE lasts one cycle, then the block lives in DIRECT.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = DIRECT;
            DIRECT:  w_state_nxt = DIRECT;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign in_ready       = (r_state == DIRECT);
    assign w_scan_chg     = 1'b0;
    assign w_scan_idx_nxt = {N{1'b0}};
    assign w_unused       = ^{w_oh_wide, mode, dwell};
`endif

    assign w_accept = in_valid && in_ready;

    // Next code, y and out_valid: an accept loads d, a scan step loads the new
    // index, otherwise the code holds. en only gates y; code keeps tracking.
    always_comb begin
        w_code_nxt      = r_code;
        w_out_valid_nxt = 1'b0;
        w_y_nxt         = {(2**N){1'b0}};
        if (w_accept) begin
            w_code_nxt      = d;
            w_out_valid_nxt = 1'b1;
        end else if (w_scan_chg) begin
            w_code_nxt      = w_scan_idx_nxt;
            w_out_valid_nxt = 1'b1;
        end else begin
            w_code_nxt      = r_code;
            w_out_valid_nxt = 1'b0;
        end
        w_oh_wide = dec_onehot(DEC_MAX_N'(w_code_nxt));
        if (en) begin
            w_y_nxt = w_oh_wide[2**N-1:0];
        end else begin
            w_y_nxt = {(2**N){1'b0}};
        end
    end

    // State, code and output registers; reset clears them without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_code      <= {N{1'b0}};
            r_y         <= {(2**N){1'b0}};
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_code      <= w_code_nxt;
            r_y         <= w_y_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    assign y         = r_y;
    assign out_valid = r_out_valid;

endmodule
